// File: rtl/cdc_fifo_nibble_packer_if.sv
// Bus bundle for cdc_fifo_nibble_packer: FIFO read port, flush request and
// the packed-word valid/ready output with its accepted-word counter.
interface cdc_fifo_nibble_packer_if #(
  parameter int DATA_WIDTH = 4,
  parameter int NIBBLES    = 2
);
  localparam int CW = $clog2(NIBBLES + 1);

  logic                          fifo_empty;
  logic [DATA_WIDTH-1:0]         fifo_read_data;
  logic                          fifo_read_increment;
  logic                          flush;
  logic [DATA_WIDTH*NIBBLES-1:0] out_data;
  logic [CW-1:0]                 out_count;
  logic                          out_valid;
  logic                          out_ready;
  logic [7:0]                    word_count;

  // Packer side.
  modport master (
    input  fifo_empty, fifo_read_data, flush, out_ready,
    output fifo_read_increment, out_data, out_count, out_valid, word_count
  );

  // FIFO / consumer side.
  modport slave (
    output fifo_empty, fifo_read_data, flush, out_ready,
    input  fifo_read_increment, out_data, out_count, out_valid, word_count
  );
endinterface

// File: rtl/cdc_fifo_nibble_packer.sv
// Drains nibbles from a first-word-fall-through FIFO read port and packs
// NIBBLES of them per output word; flush emits a partially filled word.
module cdc_fifo_nibble_packer #(
  parameter int DATA_WIDTH = 4,
  parameter int NIBBLES    = 2,
  parameter int LSB_FIRST  = 1
) (
  input  logic                      read_clock,
  input  logic                      read_reset,
  cdc_fifo_nibble_packer_if.master  bus
);
  localparam int          CW = $clog2(NIBBLES + 1);
  localparam int          WW = DATA_WIDTH * NIBBLES;
  localparam int unsigned NB = NIBBLES;
  localparam int unsigned DW = DATA_WIDTH;

  localparam logic [0:0] FILL  = 1'b0;
  localparam logic [0:0] STALL = 1'b1;

  logic [0:0]    state;
  logic [CW-1:0] idx;            // reaches NIBBLES only while stalled on a full word
  logic [WW-1:0] asm_q;
  logic [WW-1:0] asm_next;
  logic          flush_pending;
  logic [WW-1:0] out_data_q;
  logic [CW-1:0] out_count_q;
  logic          out_valid_q;
  logic [7:0]    word_count_q;

  logic          pop;
  logic          accept;
  logic          out_free;
  logic          flush_any;
  logic          complete;
  logic [CW-1:0] total;

  assign pop       = !read_reset && !bus.fifo_empty && (state == FILL);
  assign accept    = out_valid_q && bus.out_ready;
  assign out_free  = !out_valid_q || bus.out_ready;
  assign flush_any = bus.flush || flush_pending;
  assign total     = idx + CW'(pop);
  assign complete  = (state == FILL) &&
                     ((pop && (idx == CW'(NIBBLES - 1))) || (flush_any && (total != '0)));

  always_comb begin
    asm_next = asm_q;
    for (int unsigned i = 0; i < NB; i++) begin
      if (pop && (idx == CW'(i))) begin
        asm_next[((LSB_FIRST != 0) ? i : (NB - 32'd1 - i)) * DW +: DATA_WIDTH] = bus.fifo_read_data;
      end
    end
  end

  always_ff @(posedge read_clock or posedge read_reset) begin
    if (read_reset) begin
      state         <= FILL;
      idx           <= '0;
      asm_q         <= '0;
      flush_pending <= 1'b0;
      out_data_q    <= '0;
      out_count_q   <= '0;
      out_valid_q   <= 1'b0;
      word_count_q  <= '0;
    end else begin
      if (accept) begin
        word_count_q <= word_count_q + 8'd1;
        out_valid_q  <= 1'b0;
      end
      if (state == FILL) begin
        if (complete && out_free) begin
          out_data_q  <= asm_next;
          out_count_q <= total;
          out_valid_q <= 1'b1;
          idx         <= '0;
          asm_q       <= '0;
        end else begin
          asm_q <= asm_next;
          idx   <= total;
          if (complete) begin
            state <= STALL;
          end
        end
        // In FILL a flush either completes a word or is an empty no-op,
        // so the pending flag never outlives a FILL cycle.
        flush_pending <= 1'b0;
      end else begin
        flush_pending <= flush_pending | bus.flush;
        if (accept) begin
          out_data_q  <= asm_q;
          out_count_q <= idx;
          out_valid_q <= 1'b1;
          asm_q       <= '0;
          idx         <= '0;
          state       <= FILL;
        end
      end
    end
  end

  assign bus.fifo_read_increment = pop;
  assign bus.out_data            = out_data_q;
  assign bus.out_count           = out_count_q;
  assign bus.out_valid           = out_valid_q;
  assign bus.word_count          = word_count_q;
endmodule

// File: tb/tb_cdc_fifo_nibble_packer.sv
// Bench for cdc_fifo_nibble_packer: two instances (LSB_FIRST=1 and 0) driven
// with identical stimulus and compared each cycle against a queue-based model.
`timescale 1ns/1ps
module tb_cdc_fifo_nibble_packer;
  localparam int NIB = 2;
  localparam int DW  = 4;

  logic read_clock = 1'b0;
  logic read_reset;
  logic flush;
  logic out_ready;

  always #5 read_clock = ~read_clock;

  logic       tb_empty  [2];
  logic [3:0] tb_rdata  [2];
  logic       dut_pop   [2];
  logic [7:0] dut_data  [2];
  logic [1:0] dut_cnt   [2];
  logic       dut_valid [2];
  logic [7:0] dut_wc    [2];

  for (genvar g = 0; g < 2; g++) begin : g_dut
    cdc_fifo_nibble_packer_if #(.DATA_WIDTH(DW), .NIBBLES(NIB)) ifc ();
    assign ifc.fifo_empty     = tb_empty[g];
    assign ifc.fifo_read_data = tb_rdata[g];
    assign ifc.flush          = flush;
    assign ifc.out_ready      = out_ready;
    assign dut_pop[g]         = ifc.fifo_read_increment;
    assign dut_data[g]        = ifc.out_data;
    assign dut_cnt[g]         = ifc.out_count;
    assign dut_valid[g]       = ifc.out_valid;
    assign dut_wc[g]          = ifc.word_count;

    cdc_fifo_nibble_packer #(
      .DATA_WIDTH (DW),
      .NIBBLES    (NIB),
      .LSB_FIRST  ((g == 0) ? 1 : 0)
    ) u_dut (
      .read_clock (read_clock),
      .read_reset (read_reset),
      .bus        (ifc.master)
    );
  end

  // FIFO contents per instance, and the model's view of each packer.
  logic [3:0]  fq [2][$];
  logic [3:0]  mq [2][$];
  logic        m_valid [2];
  logic [7:0]  m_data  [2];
  int unsigned m_cnt   [2];
  logic        m_stall [2];
  logic        m_fp    [2];
  int unsigned m_wc    [2];
  int unsigned acc_words;

  int unsigned n_vec = 0;
  int unsigned n_err = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [7:0] pack_word(input int unsigned inst);
    logic [7:0]  v;
    int unsigned slot;
    v = 8'h00;
    for (int unsigned k = 0; k < mq[inst].size(); k++) begin
      slot = (inst == 0) ? k : (NIB - 1 - k);
      v = v | (8'(mq[inst][k]) << (4 * slot));
    end
    return v;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      mq[i].delete();
      m_valid[i] = 1'b0;
      m_data[i]  = 8'h00;
      m_cnt[i]   = 0;
      m_stall[i] = 1'b0;
      m_fp[i]    = 1'b0;
      m_wc[i]    = 0;
    end
  endtask

  task automatic emit(input int unsigned i);
    m_data[i]  = pack_word(i);
    m_cnt[i]   = mq[i].size();
    m_valid[i] = 1'b1;
    mq[i].delete();
  endtask

  task automatic model_next(input int unsigned i, input logic pop);
    logic acc, free, fa, done, load;
    acc  = m_valid[i] && out_ready;
    free = !m_valid[i] || out_ready;
    load = 1'b0;
    if (acc) begin
      m_wc[i] = (m_wc[i] + 1) % 256;
      if (i == 0) acc_words++;
    end
    if (m_stall[i]) begin
      if (flush) m_fp[i] = 1'b1;
      if (acc) begin
        emit(i);
        m_stall[i] = 1'b0;
        load = 1'b1;
      end
    end else begin
      fa = flush || m_fp[i];
      if (pop) mq[i].push_back(fq[i][0]);
      done = (mq[i].size() == NIB) || (fa && mq[i].size() != 0);
      if (done) begin
        m_fp[i] = 1'b0;
        if (free) begin
          emit(i);
          load = 1'b1;
        end else begin
          m_stall[i] = 1'b1;
        end
      end else if (mq[i].size() == 0) begin
        m_fp[i] = 1'b0;
      end else begin
        m_fp[i] = fa;
      end
    end
    if (acc && !load) m_valid[i] = 1'b0;
  endtask

  task automatic drive_fifo();
    for (int i = 0; i < 2; i++) begin
      tb_empty[i] = (fq[i].size() == 0);
      tb_rdata[i] = (fq[i].size() != 0) ? fq[i][0] : 4'h0;
    end
  endtask

  task automatic push(input logic [3:0] v);
    fq[0].push_back(v);
    fq[1].push_back(v);
  endtask

  // One clock: check the pop strobe before the edge, advance the model,
  // pop the FIFO on the DUT strobe, then check the registered outputs.
  task automatic step();
    logic mpop [2];
    logic dpop [2];
    drive_fifo();
    #1;
    for (int i = 0; i < 2; i++) begin
      mpop[i] = !read_reset && !m_stall[i] && (fq[i].size() != 0);
      dpop[i] = dut_pop[i];
      check($sformatf("pop%0d", i), dpop[i], mpop[i]);
    end
    if (read_reset) model_reset();
    else for (int i = 0; i < 2; i++) model_next(i, mpop[i]);
    @(posedge read_clock);
    #1;
    for (int i = 0; i < 2; i++) begin
      if (dpop[i] && fq[i].size() != 0) void'(fq[i].pop_front());
      check($sformatf("valid%0d", i), dut_valid[i], m_valid[i]);
      check($sformatf("data%0d", i),  dut_data[i],  m_data[i]);
      check($sformatf("count%0d", i), dut_cnt[i],   m_cnt[i]);
      check($sformatf("wc%0d", i),    dut_wc[i],    m_wc[i]);
    end
    drive_fifo();
  endtask

  initial begin
    #200us;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int guard;
    read_reset = 1'b1;
    flush      = 1'b0;
    out_ready  = 1'b0;
    acc_words  = 0;
    model_reset();
    drive_fifo();
    step();
    check("rst_valid", dut_valid[0], 1'b0);
    check("rst_wc", dut_wc[0], 8'd0);
    read_reset = 1'b0;
    step();

    // Pair 0x3, 0xA with out_ready high.
    out_ready = 1'b1;
    push(4'h3); push(4'hA);
    step(); step();
    check("t1_data_lsb", dut_data[0], 8'hA3);
    check("t2_data_msb", dut_data[1], 8'h3A);
    check("t1_count", dut_cnt[0], 2'd2);
    step();
    check("t1_wc", dut_wc[0], 8'd1);
    check("t1_valid_drop", dut_valid[0], 1'b0);

    // Back-pressure into STALL, then a flush while stalled.
    out_ready = 1'b0;
    push(4'h1); push(4'h2); push(4'h3); push(4'h4); push(4'h5);
    repeat (6) step();
    check("t3_held", dut_data[0], 8'h21);
    check("t3_no_pop", dut_pop[0], 1'b0);
    check("t3_fifo_left", fq[0].size(), 1);
    out_ready = 1'b1;
    flush = 1'b1;
    step();
    flush = 1'b0;
    check("t3_second", dut_data[0], 8'h43);
    step();
    check("t5_stall_flush", dut_data[0], 8'h05);
    check("t5_stall_flush_cnt", dut_cnt[0], 2'd1);
    step();

    // Single-nibble flush, then an empty flush.
    push(4'h7);
    step();
    flush = 1'b1; step(); flush = 1'b0;
    check("t4_partial", dut_data[0], 8'h07);
    check("t4_partial_msb", dut_data[1], 8'h70);
    check("t4_count", dut_cnt[0], 2'd1);
    step();
    flush = 1'b1; step(); flush = 1'b0;
    step();
    check("t4_empty_flush", dut_valid[0], 1'b0);

    // Flush in the same cycle as the pop of 0x9.
    push(4'h9);
    flush = 1'b1; step(); flush = 1'b0;
    check("t5_same_cycle", dut_data[0], 8'h09);
    check("t5_same_cycle_cnt", dut_cnt[0], 2'd1);
    step();

    // Asynchronous reset with a held word and idx=1.
    out_ready = 1'b0;
    push(4'h1); push(4'h2);
    step(); step();
    push(4'h3);
    step();
    #2;
    read_reset = 1'b1;
    push(4'h5);
    drive_fifo();
    #1;
    check("t6_async_valid", dut_valid[0], 1'b0);
    check("t6_async_data", dut_data[0], 8'h00);
    check("t6_async_cnt", dut_cnt[0], 2'd0);
    check("t6_async_pop", dut_pop[0], 1'b0);
    model_reset();
    step();
    read_reset = 1'b0;
    out_ready = 1'b1;
    push(4'h6);
    step(); step();
    check("t6_fresh", dut_data[0], 8'h65);
    step();

    // Randomized traffic.
    for (int n = 0; n < 400; n++) begin
      out_ready = ($urandom_range(0, 9) < 7);
      flush     = ($urandom_range(0, 9) == 0);
      if (fq[0].size() < 6) begin
        for (int k = $urandom_range(0, 2); k > 0; k--) push(4'($urandom_range(0, 15)));
      end
      step();
    end
    flush = 1'b0;
    out_ready = 1'b1;
    repeat (10) step();
    flush = 1'b1; step(); flush = 1'b0;
    repeat (4) step();

    // 256 accepted words from reset: word_count wraps to 0.
    read_reset = 1'b1;
    step();
    read_reset = 1'b0;
    acc_words = 0;
    guard = 0;
    while (acc_words < 256 && guard < 2000) begin
      if (fq[0].size() < 4) push(4'($urandom_range(0, 15)));
      step();
      guard++;
    end
    check("wrap_budget", acc_words, 256);
    check("wc_wrap", dut_wc[0], 8'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
